wb_pipe_skid: RTL and testbench
===============================

WB_PIPE_SKID -- requirements
Module: wb_pipe_skid

Interface
REQ-001 Parameter DATA_WIDTH, default 32, write-back data width per lane.
REQ-002 Parameter REG_ADDR_WIDTH, default 4, destination register address width per lane.
REQ-003 Parameter LANES, default 1, number of independent write-back lanes; legal range 1..4.
REQ-004 Parameter ZERO_REG_RO, default 0, when 1 a lane write targeting address 0 has its write enable forced to 0 at capture.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous discard of all held entries.
REQ-008 in_valid  input  1  upstream (MEM) presents a bundle.
REQ-009 in_ready  output  1  block can accept a bundle this cycle.
REQ-010 reg_wen_in  input  LANES  per-lane write enable; lane i at bit i.
REQ-011 rd_addr_in  input  LANES*REG_ADDR_WIDTH  per-lane destination; lane i at bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
REQ-012 wdata_in  input  LANES*DATA_WIDTH  per-lane data, packed as for rd_addr_in.
REQ-013 out_valid  output  1  head entry presented to WB.
REQ-014 out_ready  input  1  WB consumes head entry this cycle.
REQ-015 reg_wen_out  output  LANES  head-entry write enables, each ANDed with out_valid.
REQ-016 rd_addr_out  output  LANES*REG_ADDR_WIDTH  head-entry destinations.
REQ-017 wdata_out  output  LANES*DATA_WIDTH  head-entry data.
REQ-018 occupancy  output  2  number of held entries, 0..2.

Function
REQ-019 Storage SHALL be two bundle entries: head (drives outputs) and skid; each entry holds wen, addr, data for all lanes plus a valid bit.
REQ-020 Accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-021 in_ready SHALL be a registered signal equal to NOT skid-valid; no combinational path from out_ready to in_ready.
REQ-022 Head empty, accept: bundle SHALL load into head; out_valid high the next cycle (latency 1).
REQ-023 Head full, out_ready high, skid empty, accept: bundle SHALL replace head.
REQ-024 Head full, out_ready low, accept: bundle SHALL load into skid; in_ready low next cycle.
REQ-025 Head full, out_ready high, skid full: skid SHALL move to head and skid SHALL become empty; in_ready high next cycle.
REQ-026 Head full, out_ready high, no accept, skid empty: head SHALL become empty.
REQ-027 Bundles SHALL leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-028 Held entries SHALL not change while out_ready is low, except by flush or reset.
REQ-029 Flush SHALL clear both valid bits at the next edge and set in_ready high; a bundle offered in the flush cycle SHALL be discarded; flush overrides accept and out_ready.
REQ-030 With ZERO_REG_RO=1, a lane with rd_addr_in==0 SHALL be stored with wen=0; its addr and data are still stored.
REQ-031 occupancy SHALL equal head-valid + skid-valid and be registered.
REQ-032 reg_wen_out SHALL be all-zero whenever out_valid is low; rd_addr_out and wdata_out are don't-care then, but SHALL hold the last head contents.

Reset
REQ-033 Reset SHALL asynchronously clear head and skid: valid bits, wen, addr, data to 0.
REQ-034 During reset, outputs SHALL be: out_valid=0, reg_wen_out=0, rd_addr_out=0, wdata_out=0, occupancy=0, in_ready=1.
REQ-035 Reset asserted mid-transfer SHALL discard all held entries; the first accept after deassertion loads head.

Verification
REQ-036 LANES=1, out_ready=1, accept {wen=1, addr=3, data=0xDEADBEEF} -> next cycle out_valid=1, reg_wen_out=1, rd_addr_out=3, wdata_out=0xDEADBEEF; following cycle out_valid=0.
REQ-037 out_ready=0, accept A then B -> occupancy=2, in_ready=0, outputs show A; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A leaves.
REQ-038 Occupancy 2, assert flush with in_valid=1 (bundle C) -> next cycle occupancy=0, out_valid=0, in_ready=1; C never appears.
REQ-039 ZERO_REG_RO=1, LANES=2, accept lane0 {wen=1, addr=0}, lane1 {wen=1, addr=5} -> reg_wen_out=2'b10.
REQ-040 Occupancy 1, assert reset asynchronously between edges -> out_valid, reg_wen_out, occupancy drop to 0 immediately, in_ready=1.
REQ-041 Random in_valid/out_ready for 10k cycles against a reference FIFO model -> order preserved, no loss, occupancy never exceeds 2.

Source files
------------

// File: rtl/wb_pipe_skid.sv
// MEM->WB pipeline register with a one-entry skid buffer; in_ready is registered
// so there is no combinational path from out_ready back to the upstream stage.
module wb_pipe_skid #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned LANES          = 1,
  parameter bit          ZERO_REG_RO    = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES-1:0]                reg_wen_in,
  input  logic [LANES*REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [LANES*DATA_WIDTH-1:0]     wdata_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES-1:0]                reg_wen_out,
  output logic [LANES*REG_ADDR_WIDTH-1:0] rd_addr_out,
  output logic [LANES*DATA_WIDTH-1:0]     wdata_out,
  output logic [1:0]                      occupancy
);

  localparam int unsigned AW = LANES * REG_ADDR_WIDTH;
  localparam int unsigned DW = LANES * DATA_WIDTH;

  logic             r_head_v, r_skid_v, r_in_ready;
  logic [LANES-1:0] r_head_wen, r_skid_wen, r_wen_out;
  logic [AW-1:0]    r_head_addr, r_skid_addr;
  logic [DW-1:0]    r_head_data, r_skid_data;
  logic [1:0]       r_occ;

  logic             w_accept;
  logic [LANES-1:0] w_in_wen;
  logic             w_head_v_n, w_skid_v_n;
  logic [LANES-1:0] w_head_wen_n, w_skid_wen_n;
  logic [AW-1:0]    w_head_addr_n, w_skid_addr_n;
  logic [DW-1:0]    w_head_data_n, w_skid_data_n;

  assign w_accept = in_valid & r_in_ready;

  // Writes to register 0 are squashed at capture when it is read-only
  always_comb begin
    w_in_wen = reg_wen_in;
    if (ZERO_REG_RO) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (rd_addr_in[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) begin
          w_in_wen[i] = 1'b0;
        end
      end
    end
  end

  // Next-state for head/skid; skid is only ever filled while head is stalled
  always_comb begin
    w_head_v_n    = r_head_v;
    w_head_wen_n  = r_head_wen;
    w_head_addr_n = r_head_addr;
    w_head_data_n = r_head_data;
    w_skid_v_n    = r_skid_v;
    w_skid_wen_n  = r_skid_wen;
    w_skid_addr_n = r_skid_addr;
    w_skid_data_n = r_skid_data;
    if (flush) begin
      w_head_v_n = 1'b0;
      w_skid_v_n = 1'b0;
    end else if (!r_head_v || out_ready) begin
      if (r_head_v && r_skid_v) begin
        w_head_v_n    = 1'b1;
        w_head_wen_n  = r_skid_wen;
        w_head_addr_n = r_skid_addr;
        w_head_data_n = r_skid_data;
        w_skid_v_n    = 1'b0;
      end else if (w_accept) begin
        w_head_v_n    = 1'b1;
        w_head_wen_n  = w_in_wen;
        w_head_addr_n = rd_addr_in;
        w_head_data_n = wdata_in;
      end else begin
        w_head_v_n = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_v_n    = 1'b1;
      w_skid_wen_n  = w_in_wen;
      w_skid_addr_n = rd_addr_in;
      w_skid_data_n = wdata_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_v    <= 1'b0;
      r_head_wen  <= '0;
      r_head_addr <= '0;
      r_head_data <= '0;
      r_skid_v    <= 1'b0;
      r_skid_wen  <= '0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
      r_wen_out   <= '0;
      r_occ       <= 2'd0;
    end else begin
      r_head_v    <= w_head_v_n;
      r_head_wen  <= w_head_wen_n;
      r_head_addr <= w_head_addr_n;
      r_head_data <= w_head_data_n;
      r_skid_v    <= w_skid_v_n;
      r_skid_wen  <= w_skid_wen_n;
      r_skid_addr <= w_skid_addr_n;
      r_skid_data <= w_skid_data_n;
      r_in_ready  <= ~w_skid_v_n;
      r_wen_out   <= w_head_wen_n & {LANES{w_head_v_n}};
      r_occ       <= {1'b0, w_head_v_n} + {1'b0, w_skid_v_n};
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_head_v;
  assign reg_wen_out = r_wen_out;
  assign rd_addr_out = r_head_addr;
  assign wdata_out   = r_head_data;
  assign occupancy   = r_occ;

endmodule

// File: tb/tb_wb_pipe_skid.sv
// Directed + randomized scoreboard bench for wb_pipe_skid (1-lane and 2-lane/zero-reg-RO).
module tb_wb_pipe_skid;

  typedef struct {
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] data;
  } bundle_t;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [0:0]  reg_wen_in, reg_wen_out;
  logic [3:0]  rd_addr_in, rd_addr_out;
  logic [31:0] wdata_in, wdata_out;
  logic [1:0]  occupancy;

  logic        in_valid2, in_ready2, out_valid2;
  logic [1:0]  reg_wen_in2, reg_wen_out2, occupancy2;
  logic [7:0]  rd_addr_in2, rd_addr_out2;
  logic [63:0] wdata_in2, wdata_out2;

  int      n_vec, n_miss;
  bundle_t q[$];
  bit      m_rdy;

  wb_pipe_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_wen_in(reg_wen_in), .rd_addr_in(rd_addr_in), .wdata_in(wdata_in),
    .out_valid(out_valid), .out_ready(out_ready), .reg_wen_out(reg_wen_out),
    .rd_addr_out(rd_addr_out), .wdata_out(wdata_out), .occupancy(occupancy)
  );

  wb_pipe_skid #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .LANES(2), .ZERO_REG_RO(1'b1)) dut2 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .reg_wen_in(reg_wen_in2), .rd_addr_in(rd_addr_in2), .wdata_in(wdata_in2),
    .out_valid(out_valid2), .out_ready(1'b1), .reg_wen_out(reg_wen_out2),
    .rd_addr_out(rd_addr_out2), .wdata_out(wdata_out2), .occupancy(occupancy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic [3:0] addr, input logic [31:0] data);
    in_valid   = v;
    reg_wen_in = wen;
    rd_addr_in = addr;
    wdata_in   = data;
  endtask

  // Reference FIFO: update from the inputs about to be sampled, clock, compare head
  task automatic cycle();
    bundle_t b;
    bit      acc;
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && m_rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        b.wen = reg_wen_in[0]; b.addr = rd_addr_in; b.data = wdata_in;
        q.push_back(b);
      end
    end
    m_rdy = (q.size() < 2);
    @(posedge clk); #1;
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("head_wen", 64'(reg_wen_out), 64'(q[0].wen));
      chk("head_addr", 64'(rd_addr_out), 64'(q[0].addr));
      chk("head_data", 64'(wdata_out), 64'(q[0].data));
    end else begin
      chk("idle_wen", 64'(reg_wen_out), 64'd0);
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0; m_rdy = 1'b1;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    in_valid2 = 1'b0; reg_wen_in2 = 2'b00; rd_addr_in2 = 8'd0; wdata_in2 = 64'd0;

    // Outputs while reset is held
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wen", 64'(reg_wen_out), 64'd0);
    chk("rst_addr", 64'(rd_addr_out), 64'd0);
    chk("rst_data", 64'(wdata_out), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Single bundle, latency 1, then drains
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
    cycle();
    chk("d36_valid", 64'(out_valid), 64'd1);
    chk("d36_wen", 64'(reg_wen_out), 64'd1);
    chk("d36_addr", 64'(rd_addr_out), 64'd3);
    chk("d36_data", 64'(wdata_out), 64'hDEADBEEF);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    cycle();
    chk("d36_drain_valid", 64'(out_valid), 64'd0);
    chk("d36_drain_wen", 64'(reg_wen_out), 64'd0);
    chk("d36_hold_addr", 64'(rd_addr_out), 64'd3);

    // Stall: A then B fills head+skid, hold while stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd1, 32'hAAAA0001);
    cycle();
    drive(1'b1, 1'b0, 4'd2, 32'hBBBB0002);
    cycle();
    chk("d37_occ", 64'(occupancy), 64'd2);
    chk("d37_rdy", 64'(in_ready), 64'd0);
    chk("d37_headA", 64'(wdata_out), 64'hAAAA0001);
    drive(1'b1, 1'b1, 4'd7, 32'h77777777);
    cycle();
    cycle();
    chk("d37_holdA", 64'(wdata_out), 64'hAAAA0001);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("d37_headB", 64'(wdata_out), 64'hBBBB0002);
    chk("d37_wenB", 64'(reg_wen_out), 64'd0);
    chk("d37_rdy_back", 64'(in_ready), 64'd1);
    cycle();
    chk("d37_empty", 64'(out_valid), 64'd0);

    // Flush with two held entries and a bundle C offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd4, 32'h44444444);
    cycle();
    drive(1'b1, 1'b1, 4'd5, 32'h55555555);
    cycle();
    flush = 1'b1;
    drive(1'b1, 1'b1, 4'd12, 32'hCCCCCCCC);
    out_ready = 1'b1;
    cycle();
    chk("d38_occ", 64'(occupancy), 64'd0);
    chk("d38_valid", 64'(out_valid), 64'd0);
    chk("d38_rdy", 64'(in_ready), 64'd1);
    flush = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    cycle();
    chk("d38_noC", 64'(out_valid), 64'd0);

    // Back-to-back streaming: each accept replaces the consumed head
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'(i + 8), 32'h1000 + 32'(i));
      cycle();
      chk("stream_data", 64'(wdata_out), 64'h1000 + 64'(i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    cycle();

    // Asynchronous reset between edges with one entry held
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd9, 32'h99999999);
    cycle();
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("d40_valid", 64'(out_valid), 64'd0);
    chk("d40_wen", 64'(reg_wen_out), 64'd0);
    chk("d40_occ", 64'(occupancy), 64'd0);
    chk("d40_rdy", 64'(in_ready), 64'd1);
    q.delete(); m_rdy = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 4'd6, 32'h66666666);
    cycle();
    chk("d40_reload", 64'(wdata_out), 64'h66666666);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    out_ready = 1'b1;
    cycle();

    // Two lanes, register 0 read-only: lane0 write squashed, addr/data kept
    in_valid2 = 1'b1; reg_wen_in2 = 2'b11; rd_addr_in2 = {4'd5, 4'd0};
    wdata_in2 = {32'h22222222, 32'h11111111};
    @(posedge clk); #1;
    chk("d39_wen", 64'(reg_wen_out2), 64'h2);
    chk("d39_addr", 64'(rd_addr_out2), 64'h50);
    chk("d39_data", wdata_out2, 64'h2222222211111111);
    rd_addr_in2 = {4'd3, 4'd1};
    @(posedge clk); #1;
    chk("d39_both_wen", 64'(reg_wen_out2), 64'h3);
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("d39_idle_wen", 64'(reg_wen_out2), 64'h0);

    // Random traffic against the reference FIFO
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("final_empty", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
